if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU; sits directly upstream of id_stage.
- Owns the PC, drives a request/acknowledge instruction-memory port, and holds the IF/ID pipeline register.
- Produces if_inst, if_pc4, IF_ins_type and IF_ins_number for id_stage.
- Obeys the stall (cu_wpcir) and branch/jump redirect (cu_branch, branch_target) signals returned from ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word injected as a bubble.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- cu_wpcir  in  1  1 = PC/IR may advance; 0 = stall (hold PC and IF/ID).
- cu_branch  in  1  1 = redirect fetch to branch_target this cycle.
- branch_target  in  32  redirect address from ID.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (always equals PC).
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_ack  in  1  memory returns the word for the imem_addr presented in the same cycle.
- if_inst  out  32  IF/ID instruction.
- if_pc4  out  32  IF/ID PC+4.
- if_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- IF_ins_type  out  4  class of if_inst.
- IF_ins_number  out  4  sequence tag of if_inst.

Behaviour:
- Reset (rst=0 at a rising edge), all outputs registered:
  - pc=RESET_PC; state=REQ.
  - if_inst=NOP_INST; if_pc4=0; if_valid=0.
  - IF_ins_type=0; IF_ins_number=0; skid buffer cleared.
- Reset dominates all other inputs, including mid-request and HOLD.
- imem_addr=pc at all times. imem_req=1 in REQ, 0 in HOLD.
- The memory tolerates an address change while a request is pending; no in-flight request is tracked.
- State REQ, evaluated in this priority order:
  1. cu_branch=1: pc<=branch_target; IF/ID<=bubble; any ack is discarded. Stay REQ. Branch wins even if cu_wpcir=0.
  2. imem_ack=1 and cu_wpcir=1: if_inst<=imem_rdata; if_pc4<=pc+4; if_valid<=1; pc<=pc+4; IF_ins_number<=IF_ins_number+1. Stay REQ.
  3. imem_ack=1 and cu_wpcir=0: skid<={imem_rdata, pc+4}; IF/ID unchanged; pc unchanged; go HOLD.
  4. imem_ack=0 and cu_wpcir=1: IF/ID<=bubble; pc unchanged.
  5. imem_ack=0 and cu_wpcir=0: IF/ID unchanged.
- State HOLD:
  - cu_branch=1: drop skid; pc<=branch_target; IF/ID<=bubble; go REQ.
  - cu_wpcir=1: IF/ID<=skid, valid=1; pc<=pc+4; IF_ins_number++; go REQ.
  - Otherwise: hold everything.
- Latency: an acked word appears on if_inst the next cycle; with no stall and single-cycle ack, fetch throughput is 1 instruction/cycle.
- Bubble: if_inst=NOP_INST, if_pc4 unchanged, if_valid=0, IF_ins_type=0. IF_ins_number does not increment on a bubble.
- IF_ins_number is 4-bit and wraps 15 -> 0.
- pc+4 is mod 2^32: 32'hFFFF_FFFC wraps to 0. The low two bits of branch_target are forced to 0.
- IF_ins_type is registered alongside if_inst, classified from the opcode field [31:26]:
  - 1 = R-type (opcode 0, inst != 0)
  - 2 = load (opcode 0x23)
  - 3 = store (opcode 0x2B)
  - 4 = branch (opcode 0x04/0x05)
  - 5 = jump (opcode 0x02/0x03)
  - 6 = I-type ALU (opcode 0x08–0x0F)
  - 15 = other
  - 0 = bubble or all-zero word

Decomposition:
- Shared package pipe_pkg: opcode constants, INS_TYPE_* encodings (0,1..6,15), NOP_INST, fetch-state enum {REQ, HOLD}.
- Sub-module ins_classifier: combinational 32-bit instruction -> 4-bit type. id_stage reuses the same module.

Test Plan:
1. Reset, then ack every cycle, memory returning 8c090014, 00a64004, 01074806 -> each appears one cycle later with if_pc4 = 4, 8, 12; types 2, 1, 1; numbers 1, 2, 3; if_valid=1.
2. cu_wpcir=0 for 2 cycles while ack=1 on 01075007 at pc=0x10 -> state HOLD, imem_req=0, IF/ID frozen. When wpcir returns to 1, if_inst=01075007, if_pc4=0x14, pc=0x14.
3. cu_branch=1 with branch_target=0x44 and ack=1 on 0c000011 -> word discarded, if_valid=0, IF_ins_type=0. Next fetch uses imem_addr=0x44.
4. imem_ack held 0 for 3 cycles with wpcir=1 -> 3 bubbles, pc constant, IF_ins_number constant. Ack on 27eb0008 -> if_inst=27eb0008, type 6.
5. Branch in HOLD (target 0x80) with wpcir=0 -> skid dropped, if_valid=0, pc=0x80, state REQ.
6. Assert rst=0 mid-HOLD, and separately run 16 consecutive valid fetches -> reset values restored on the next edge; IF_ins_number wraps to 0 on the 16th instruction.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined CPU front end: opcode constants,
// instruction-class encodings, the bubble word and the fetch-state enum.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned TYPE_W = 4;
  localparam int unsigned NUM_W  = 4;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  // Opcode field [31:26]
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // Instruction classes carried alongside the IF/ID instruction
  localparam logic [TYPE_W-1:0] INS_TYPE_NONE   = 4'd0;
  localparam logic [TYPE_W-1:0] INS_TYPE_RTYPE  = 4'd1;
  localparam logic [TYPE_W-1:0] INS_TYPE_LOAD   = 4'd2;
  localparam logic [TYPE_W-1:0] INS_TYPE_STORE  = 4'd3;
  localparam logic [TYPE_W-1:0] INS_TYPE_BRANCH = 4'd4;
  localparam logic [TYPE_W-1:0] INS_TYPE_JUMP   = 4'd5;
  localparam logic [TYPE_W-1:0] INS_TYPE_ALUI   = 4'd6;
  localparam logic [TYPE_W-1:0] INS_TYPE_OTHER  = 4'd15;

  typedef enum logic [0:0] {
    FETCH_REQ  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_t;

  // Word acked while ID was stalled, parked until the stall releases
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } skid_t;

endpackage

// File: rtl/ins_classifier.sv
// Combinational instruction classifier shared by if_stage and id_stage.
//   inst       : 32-bit instruction word
//   ins_type_c : 4-bit class (INS_TYPE_*), 0 for the all-zero word
module ins_classifier
  import pipe_pkg::*;
(
  input  logic [XLEN-1:0]   inst,
  output logic [TYPE_W-1:0] ins_type_c
);

  logic [OP_W-1:0] opcode;

  assign opcode = inst[31:26];

  // Opcode decode; the all-zero word is a bubble, not an R-type
  always_comb begin
    ins_type_c = INS_TYPE_OTHER;
    if (inst == NOP_INST) begin
      ins_type_c = INS_TYPE_NONE;
    end else begin
      case (opcode) inside
        OP_RTYPE:         ins_type_c = INS_TYPE_RTYPE;
        OP_LW:            ins_type_c = INS_TYPE_LOAD;
        OP_SW:            ins_type_c = INS_TYPE_STORE;
        OP_BEQ, OP_BNE:   ins_type_c = INS_TYPE_BRANCH;
        OP_J, OP_JAL:     ins_type_c = INS_TYPE_JUMP;
        [OP_ADDI:OP_LUI]: ins_type_c = INS_TYPE_ALUI;
        default:          ins_type_c = INS_TYPE_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request/ack port,
// parks a word in a one-entry skid buffer when ID stalls, and holds IF/ID.
//   clk, rst                 : clock, synchronous active-low reset
//   cu_wpcir                 : 1 = advance, 0 = stall PC and IF/ID
//   cu_branch, branch_target : redirect fetch (wins over stall)
//   imem_req, imem_addr      : fetch request and address (address == PC)
//   imem_rdata, imem_ack     : returned word for the current address
//   if_inst, if_pc4, if_valid, IF_ins_type, IF_ins_number : IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_wpcir,
  input  logic        cu_branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number
);

  import pipe_pkg::*;

  fetch_state_t      state, state_d;
  logic [XLEN-1:0]   pc, pc_d;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   target_aligned;
  skid_t             skid, skid_d;
  logic [XLEN-1:0]   fetch_word;
  logic [XLEN-1:0]   fetch_pc4;
  logic [TYPE_W-1:0] fetch_type_c;
  logic [XLEN-1:0]   inst_d;
  logic [XLEN-1:0]   pc4_d;
  logic              valid_d;
  logic [TYPE_W-1:0] type_d;
  logic [NUM_W-1:0]  num_d;
  logic              load;
  logic              bubble;

  assign imem_addr      = pc;
  assign imem_req       = (state == FETCH_REQ);
  assign pc_plus4       = pc + 32'd4;
  assign target_aligned = {branch_target[31:2], 2'b00};

  // Word headed for IF/ID: the parked one when leaving HOLD, else memory
  assign fetch_word = (state == FETCH_HOLD) ? skid.inst : imem_rdata;
  assign fetch_pc4  = (state == FETCH_HOLD) ? skid.pc4  : pc_plus4;

  ins_classifier u_classifier (
    .inst       (fetch_word),
    .ins_type_c (fetch_type_c)
  );

  // Next-state, PC, skid and IF/ID update
  always_comb begin
    state_d = state;
    pc_d    = pc;
    skid_d  = skid;
    inst_d  = if_inst;
    pc4_d   = if_pc4;
    valid_d = if_valid;
    type_d  = IF_ins_type;
    num_d   = IF_ins_number;
    load    = 1'b0;
    bubble  = 1'b0;

    case (state)
      FETCH_REQ: begin
        if (cu_branch) begin
          // Any ack this cycle belongs to the wrong path and is dropped
          pc_d   = target_aligned;
          bubble = 1'b1;
        end else if (imem_ack && cu_wpcir) begin
          load = 1'b1;
          pc_d = pc_plus4;
        end else if (imem_ack) begin
          skid_d  = '{inst: imem_rdata, pc4: pc_plus4};
          state_d = FETCH_HOLD;
        end else if (cu_wpcir) begin
          bubble = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (cu_branch) begin
          pc_d    = target_aligned;
          skid_d  = '0;
          bubble  = 1'b1;
          state_d = FETCH_REQ;
        end else if (cu_wpcir) begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase

    if (bubble) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      type_d  = INS_TYPE_NONE;
    end
    if (load) begin
      inst_d  = fetch_word;
      pc4_d   = fetch_pc4;
      valid_d = 1'b1;
      type_d  = fetch_type_c;
      num_d   = NUM_W'(IF_ins_number + 4'd1);
    end
  end

  // State, PC, skid and IF/ID registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= FETCH_REQ;
      pc            <= RESET_PC;
      skid          <= '0;
      if_inst       <= NOP_INST;
      if_pc4        <= '0;
      if_valid      <= 1'b0;
      IF_ins_type   <= INS_TYPE_NONE;
      IF_ins_number <= '0;
    end else begin
      state         <= state_d;
      pc            <= pc_d;
      skid          <= skid_d;
      if_inst       <= inst_d;
      if_pc4        <= pc4_d;
      if_valid      <= valid_d;
      IF_ins_type   <= type_d;
      IF_ins_number <= num_d;
    end
  end

endmodule
